display_blink_ctrl: RTL and testbench
=====================================

Name: display_blink_ctrl

Overview:
Blink and enable controller for the alarm-clock display path.
- A 16-bit cycle counter divides Clk into a half-period tick that toggles a BLINK square wave.
- Combinational logic turns mode (S) and field-select (CW, CW1) inputs into per-digit-group enables E[2:0] and a status-text select B1.
- A 3-to-8 decoder drives the one-hot day LEDs.

Parameters:
HALF_PERIOD, 500, terminal count; BLINK toggles every HALF_PERIOD+1 cycles (counter runs 0..HALF_PERIOD).
CNT_W, 16, counter width.

Ports:
Clk  in  1  system clock, all state on rising edge
Clr  in  1  synchronous active-high reset
S  in  2  mode: 00 run, 01 set clock, 10 set alarm, 11 alarm on/off edit
CW  in  2  clock-set field: 00 minutes, 01 hours, 10 day, 11 none
CW1  in  2  alarm-set field, same encoding as CW
day_sel  in  3  day index 0..6 (7 = no day)
dec_en  in  1  day decoder enable
count  out  16  current counter value
tick  out  1  high for exactly the one cycle when count == HALF_PERIOD
BLINK  out  1  blink square wave
E  out  3  enables: E[0] minutes digits, E[1] hour digits, E[2] day LEDs
B1  out  1  1 = hour digits show alarm on/off text, not hours
days  out  7  one-hot day LEDs

Behaviour:
- Counter:
  - Clr: count <= 0.
  - Else if count == HALF_PERIOD: count <= 0.
  - Else count <= count + 1.
  - Never exceeds HALF_PERIOD; no wrap at 0xFFFF in practice.
- tick = (count == HALF_PERIOD), combinational.
- BLINK:
  - Clr: BLINK <= 1.
  - Else if tick: BLINK <= ~BLINK.
  - Period = 2*(HALF_PERIOD+1) = 1002 cycles, 50% duty.
- Clr has priority over tick in the same cycle.
- Clr mid-count restarts the phase: count 0, BLINK 1.
- Enables and B1 are combinational from S, CW, CW1, BLINK:
  - S=00: E=111, B1=0.
  - S=01: field selected by CW gets BLINK, others 1. CW=00 → E[0]=BLINK; 01 → E[1]=BLINK; 10 → E[2]=BLINK; 11 → E=111. B1=0.
  - S=10: same rule using CW1; CW ignored. B1=0.
  - S=11: B1=1, E[1]=BLINK, E[0]=0, E[2]=0; CW and CW1 ignored.
- Day decoder, combinational:
  - dec_en=1 and day_sel=k (k<7): days[k]=1, all other bits 0.
  - day_sel=7 or dec_en=0: days=0.
- Reset values: count=0, tick=0 (unless HALF_PERIOD=0), BLINK=1. E, B1 and days follow their inputs, e.g. E=111 when S=00.

Decomposition:
- Shared package: HALF_PERIOD default, mode encodings (MODE_RUN=00, MODE_SET_CLK=01, MODE_SET_ALM=10, MODE_ALM_EN=11), field encodings (FLD_MIN=00, FLD_HR=01, FLD_DAY=10, FLD_NONE=11).
- One sub-module: blink_timebase (counter + tick + BLINK toggle).
- Enable logic and day decoder stay inline in the top.

Test Plan:
- Reset/timebase: hold Clr 2 cycles, release.
  - count 0,1,2,…; tick first high when count=500.
  - count=0 the following cycle; BLINK falls 1→0 on that edge; next toggle 501 cycles later.
- Clr mid-count: assert Clr at count=300 → next cycle count=0, BLINK=1; tick does not fire at the old phase.
- Mode run: S=00, any CW/CW1 → E=111, B1=0 across both BLINK phases.
- Set clock: S=01, sweep CW 00/01/10/11.
  - E = {1,1,BLINK}, {1,BLINK,1}, {BLINK,1,1}, 111.
  - Check with BLINK=0 and BLINK=1; changing CW1 has no effect.
- Alarm modes: S=10, CW1=01 → E={1,BLINK,1}. S=11 → B1=1, E={0,BLINK,0}.
- Decoder: dec_en=1, day_sel 0..7 → days 0000001, 0000010, …, 1000000, then 0000000 for day_sel=7. dec_en=0, day_sel=3 → 0000000.

Source files
------------

// File: rtl/display_blink_ctrl_pkg.sv
// Shared constants, mode/field encodings and the field-enable helper
// for the alarm-clock display blink controller.
package display_blink_ctrl_pkg;

    localparam int HALF_PERIOD_DEF = 500;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_CLK = 2'b01,
        MODE_SET_ALM = 2'b10,
        MODE_ALM_EN  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        FLD_MIN  = 2'b00,
        FLD_HR   = 2'b01,
        FLD_DAY  = 2'b10,
        FLD_NONE = 2'b11
    } field_e;

    // The field being edited follows BLINK; every other group stays lit.
    function automatic logic [2:0] field_en(input logic [1:0] fld, input logic blink);
        logic [2:0] en;
        en = 3'b111;
        case (field_e'(fld))
            FLD_MIN:  en[0] = blink;
            FLD_HR:   en[1] = blink;
            FLD_DAY:  en[2] = blink;
            default:  en    = 3'b111;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/display_blink_ctrl_if.sv
// Display-control bundle: mode/field/day inputs and enable/blink outputs.
interface display_blink_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       S;
    logic [1:0]       CW;
    logic [1:0]       CW1;
    logic [2:0]       day_sel;
    logic             dec_en;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             BLINK;
    logic [2:0]       E;
    logic             B1;
    logic [6:0]       days;

    modport master (
        output S, CW, CW1, day_sel, dec_en,
        input  count, tick, BLINK, E, B1, days
    );

    modport slave (
        input  S, CW, CW1, day_sel, dec_en,
        output count, tick, BLINK, E, B1, days
    );
endinterface

// File: rtl/display_blink_ctrl_blink_timebase.sv
// Free-running 0..HALF_PERIOD counter with terminal tick and a BLINK
// square wave that toggles on every tick.
module blink_timebase #(
    parameter int HALF_PERIOD = 500,
    parameter int CNT_W       = 16
) (
    input  logic             i_Clk,
    input  logic             i_Clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tick,
    output logic             o_blink
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_PERIOD);

    logic [CNT_W-1:0] r_count;
    logic             r_blink;
    logic             w_tick;

    assign w_tick = (r_count == TERM);

    // Counter and BLINK state; Clr wins over a coincident tick.
    always_ff @(posedge i_Clk) begin
        if (i_Clr) begin
            r_count <= {CNT_W{1'b0}};
            r_blink <= 1'b1;
        end else if (w_tick) begin
            r_count <= {CNT_W{1'b0}};
            r_blink <= ~r_blink;
        end else begin
            r_count <= r_count + CNT_W'(1);
            r_blink <= r_blink;
        end
    end

    assign o_count = r_count;
    assign o_tick  = w_tick;
    assign o_blink = r_blink;
endmodule

// File: rtl/display_blink_ctrl.sv
// Alarm-clock display blink controller: timebase, per-group digit enables,
// status-text select and one-hot day LED decoder.
module display_blink_ctrl
    import display_blink_ctrl_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input logic                 Clk,
    input logic                 Clr,
    display_blink_ctrl_if.slave bus
);
    logic [CNT_W-1:0] w_count;
    logic             w_tick;
    logic             w_blink;
    logic [2:0]       w_en;
    logic             w_b1;
    logic [7:0]       w_onehot;
    logic [6:0]       w_days;

    blink_timebase #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_timebase (
        .i_Clk   (Clk),
        .i_Clr   (Clr),
        .o_count (w_count),
        .o_tick  (w_tick),
        .o_blink (w_blink)
    );

    // Digit-group enables and alarm on/off text select from the edit mode.
    always_comb begin
        w_en = 3'b111;
        w_b1 = 1'b0;
        case (mode_e'(bus.S))
            MODE_RUN:     w_en = 3'b111;
            MODE_SET_CLK: w_en = field_en(bus.CW, w_blink);
            MODE_SET_ALM: w_en = field_en(bus.CW1, w_blink);
            MODE_ALM_EN: begin
                w_en = {1'b0, w_blink, 1'b0};
                w_b1 = 1'b1;
            end
            default: begin
                w_en = 3'b111;
                w_b1 = 1'b0;
            end
        endcase
    end

    assign w_onehot = 8'd1 << bus.day_sel;

    // Day LEDs: day_sel 7 has no LED, so it blanks like dec_en low.
    always_comb begin
        w_days = 7'b0000000;
        if (bus.dec_en && (bus.day_sel != 3'd7)) begin
            w_days = w_onehot[6:0];
        end else begin
            w_days = 7'b0000000;
        end
    end

    assign bus.count = w_count;
    assign bus.tick  = w_tick;
    assign bus.BLINK = w_blink;
    assign bus.E     = w_en;
    assign bus.B1    = w_b1;
    assign bus.days  = w_days;
endmodule

// File: tb/tb_display_blink_ctrl.sv
// Directed self-checking bench for display_blink_ctrl.
module tb_display_blink_ctrl;
    logic Clk;
    logic Clr;
    int   n_checks;
    int   n_fail;

    display_blink_ctrl_if bus ();

    display_blink_ctrl dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then sample 1 time unit later.
    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] s, input logic [1:0] cw, input logic [1:0] cw1);
        bus.S   = s;
        bus.CW  = cw;
        bus.CW1 = cw1;
        #1;
    endtask

    task automatic mode_checks(input logic b);
        check("blink_phase", 16'(bus.BLINK), 16'(b));
        set_mode(2'b00, 2'b00, 2'b01);
        check("run_E_a", 16'(bus.E), 16'(3'b111));
        check("run_B1", 16'(bus.B1), 16'(1'b0));
        set_mode(2'b00, 2'b10, 2'b11);
        check("run_E_b", 16'(bus.E), 16'(3'b111));
        set_mode(2'b01, 2'b00, 2'b10);
        check("setclk_min", 16'(bus.E), 16'({1'b1, 1'b1, b}));
        check("setclk_B1", 16'(bus.B1), 16'(1'b0));
        set_mode(2'b01, 2'b00, 2'b01);
        check("setclk_min_cw1", 16'(bus.E), 16'({1'b1, 1'b1, b}));
        set_mode(2'b01, 2'b01, 2'b00);
        check("setclk_hr", 16'(bus.E), 16'({1'b1, b, 1'b1}));
        set_mode(2'b01, 2'b10, 2'b00);
        check("setclk_day", 16'(bus.E), 16'({b, 1'b1, 1'b1}));
        set_mode(2'b01, 2'b11, 2'b00);
        check("setclk_none", 16'(bus.E), 16'(3'b111));
        set_mode(2'b10, 2'b00, 2'b01);
        check("setalm_hr", 16'(bus.E), 16'({1'b1, b, 1'b1}));
        check("setalm_B1", 16'(bus.B1), 16'(1'b0));
        set_mode(2'b10, 2'b01, 2'b00);
        check("setalm_min", 16'(bus.E), 16'({1'b1, 1'b1, b}));
        set_mode(2'b10, 2'b01, 2'b10);
        check("setalm_day", 16'(bus.E), 16'({b, 1'b1, 1'b1}));
        set_mode(2'b10, 2'b00, 2'b11);
        check("setalm_none", 16'(bus.E), 16'(3'b111));
        set_mode(2'b11, 2'b00, 2'b00);
        check("almen_E_a", 16'(bus.E), 16'({1'b0, b, 1'b0}));
        check("almen_B1_a", 16'(bus.B1), 16'(1'b1));
        set_mode(2'b11, 2'b10, 2'b01);
        check("almen_E_b", 16'(bus.E), 16'({1'b0, b, 1'b0}));
        check("almen_B1_b", 16'(bus.B1), 16'(1'b1));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        Clr         = 1'b1;
        bus.S       = 2'b00;
        bus.CW      = 2'b00;
        bus.CW1     = 2'b00;
        bus.day_sel = 3'd0;
        bus.dec_en  = 1'b0;

        // Reset and first half-period.
        cycles(2);
        check("rst_count", bus.count, 16'd0);
        check("rst_tick", 16'(bus.tick), 16'd0);
        check("rst_blink", 16'(bus.BLINK), 16'd1);
        check("rst_E", 16'(bus.E), 16'(3'b111));
        check("rst_B1", 16'(bus.B1), 16'd0);
        Clr = 1'b0;
        cycles(1);
        check("count_1", bus.count, 16'd1);
        cycles(1);
        check("count_2", bus.count, 16'd2);
        cycles(497);
        check("count_499", bus.count, 16'd499);
        check("tick_499", 16'(bus.tick), 16'd0);
        cycles(1);
        check("count_500", bus.count, 16'd500);
        check("tick_500", 16'(bus.tick), 16'd1);
        check("blink_pre", 16'(bus.BLINK), 16'd1);
        cycles(1);
        check("wrap_count", bus.count, 16'd0);
        check("wrap_tick", 16'(bus.tick), 16'd0);
        check("blink_fall", 16'(bus.BLINK), 16'd0);

        // Clr mid-count restarts the phase.
        cycles(300);
        check("mid_count", bus.count, 16'd300);
        check("mid_blink", 16'(bus.BLINK), 16'd0);
        Clr = 1'b1;
        cycles(1);
        check("clr_count", bus.count, 16'd0);
        check("clr_blink", 16'(bus.BLINK), 16'd1);
        Clr = 1'b0;
        cycles(200);
        check("old_phase_count", bus.count, 16'd200);
        check("old_phase_tick", 16'(bus.tick), 16'd0);
        check("old_phase_blink", 16'(bus.BLINK), 16'd1);
        cycles(300);
        check("new_tick", 16'(bus.tick), 16'd1);
        cycles(1);
        check("new_fall", 16'(bus.BLINK), 16'd0);

        // Next toggle is 501 edges later.
        cycles(500);
        check("hold_blink", 16'(bus.BLINK), 16'd0);
        check("hold_tick", 16'(bus.tick), 16'd1);
        cycles(1);
        check("rise_blink", 16'(bus.BLINK), 16'd1);

        mode_checks(1'b1);
        for (int i = 0; i < 600 && bus.BLINK !== 1'b0; i++) begin
            @(posedge Clk);
            #1;
        end
        check("blink_wait", 16'(bus.BLINK), 16'd0);
        mode_checks(1'b0);

        // Day decoder.
        bus.dec_en = 1'b1;
        bus.day_sel = 3'd0; #1; check("day0", 16'(bus.days), 16'(7'b0000001));
        bus.day_sel = 3'd1; #1; check("day1", 16'(bus.days), 16'(7'b0000010));
        bus.day_sel = 3'd2; #1; check("day2", 16'(bus.days), 16'(7'b0000100));
        bus.day_sel = 3'd3; #1; check("day3", 16'(bus.days), 16'(7'b0001000));
        bus.day_sel = 3'd4; #1; check("day4", 16'(bus.days), 16'(7'b0010000));
        bus.day_sel = 3'd5; #1; check("day5", 16'(bus.days), 16'(7'b0100000));
        bus.day_sel = 3'd6; #1; check("day6", 16'(bus.days), 16'(7'b1000000));
        bus.day_sel = 3'd7; #1; check("day7", 16'(bus.days), 16'(7'b0000000));
        bus.dec_en  = 1'b0;
        bus.day_sel = 3'd3; #1; check("day_dis", 16'(bus.days), 16'(7'b0000000));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
